data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder for the single-cycle MIPS core's data port: it answers the `memwrite`/`dataadr`/`writedata` bus that `top` drives and returns `readdata`. It also captures every accepted store into a small trace FIFO that a debug reader drains. It raises sticky pass/fail flags when the program's completion store lands. It sits beside the core in `top` and replaces the bare RAM model, so benches and board-level debug see stores without probing internals.

## Interface
- `AW`, default 6: word-address bits; the memory holds 2^AW 32-bit words.
- `TRACE_DEPTH`, default 8: trace FIFO entries; must be a power of two, at least 2.
- `PASS_ADDR`, default 32'd84: byte address of the completion store.
- `PASS_DATA`, default 32'd7: value that signals success at `PASS_ADDR`.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `memwrite` input 1: store strobe from the core.
- `dataadr` input 32: byte address from the core.
- `writedata` input 32: store data from the core.
- `readdata` output 32: load data; combinational.
- `misaligned` output 1: sticky; a store with `dataadr[1:0]!=0` was seen.
- `trace_valid` output 1: the trace FIFO is non-empty.
- `trace_ready` input 1: the reader pops the head entry.
- `trace_addr` output 32: head entry, store address.
- `trace_data` output 32: head entry, store data.
- `trace_overflow` output 1: sticky; a store was dropped because the FIFO was full.
- `store_count` output 16: count of accepted stores; saturates.
- `pass` output 1: sticky; the completion store carried `PASS_DATA`.
- `fail` output 1: sticky; the completion store carried any other value.

## Operation
- Word index is `dataadr[AW+1:2]`. Upper address bits are ignored, so addresses wrap modulo 2^(AW+2).
- `readdata` is always `mem[index]`. The low two address bits are ignored on reads.
- Accepted store: `memwrite=1` and `dataadr[1:0]==0` at a rising edge. On an accepted store:
  - `mem[index]<=writedata`.
  - The trace FIFO pushes {dataadr, writedata}.
  - `store_count` increments and holds at 16'hFFFF.
- Misaligned store: `memwrite=1` and `dataadr[1:0]!=0`. Memory is unchanged, nothing is traced, `store_count` is unchanged, and `misaligned` is set.
- Completion check on an accepted store with `dataadr==PASS_ADDR` (full 32-bit compare):
  - `writedata==PASS_DATA` sets `pass`; any other value sets `fail`.
  - Both flags may end up set; neither clears except by reset.
- Trace FIFO is show-ahead: `trace_addr`/`trace_data` present the head while `trace_valid=1`.
  - Pop occurs when `trace_valid && trace_ready`.
  - Pop while empty: ignored.
  - Push while full without a pop in the same cycle: the entry is dropped and `trace_overflow` is set.
  - Push while full with a pop in the same cycle: both happen; occupancy stays at `TRACE_DEPTH`.
  - Push while empty: no pass-through; `trace_valid` rises the next cycle.
- Pointers are log2(`TRACE_DEPTH`) bits plus one wrap bit. Full means the pointers are equal except for the wrap bit.

## Timing
- Reset (`rst=0`, asynchronous):
  - `misaligned`, `trace_valid`, `trace_overflow`, `pass`, `fail` = 0.
  - `store_count` = 0.
  - `trace_addr`/`trace_data` = 0.
  - FIFO pointers cleared.
  - Memory array contents are not reset.
- Reset asserted mid-operation discards all FIFO entries and flags immediately; memory keeps its contents.
- Store to read: a load from the same word in the cycle of the store returns the old value; the new value is visible after the edge.
- Store to trace: `trace_valid` and the new head appear 1 cycle after the storing edge when the FIFO was empty.
- Store to flags and count: `pass`, `fail`, `misaligned` and `store_count` update at the storing edge, with 1-cycle latency.

## Configuration
- `DMEM_TRACE_EN` defined: the trace FIFO and `trace_overflow` are built as specified above.
- `DMEM_TRACE_EN` undefined: no FIFO storage is built.
  - `trace_valid`, `trace_overflow`, `trace_addr` and `trace_data` are tied to 0, and `trace_ready` is ignored.
  - Memory, `store_count`, `misaligned`, `pass` and `fail` are unchanged.

## Test plan
- Store 32'h0000_0007 to address 84 → `pass=1`, `fail=0`, `store_count=1`; a load from address 84 returns 7.
- Store 32'h0000_0005 to address 84, then 7 to address 84 → `fail=1` after the first store and `pass=1` after the second; both stay high until reset.
- Store 32'hDEAD_BEEF to address 82 → `misaligned=1`; a load from address 80 returns its prior value; `store_count` is unchanged; FIFO stays empty.
- With `trace_ready=0`, perform 9 stores to addresses 0,4,…,32 (depth 8) → `trace_valid=1`, `trace_overflow=1`, `store_count=9`. Then raise `trace_ready` → entries drain in order 0..28 over 8 cycles, and `trace_valid=0` afterwards.
- FIFO full and `trace_ready=1` while storing 32'h1234 to address 40 → no overflow; the last popped entry is {40, 32'h1234}.
- Assert `rst=0` between clock edges while the FIFO holds 3 entries → `trace_valid` drops immediately and all flags and the count read 0; data stored before reset is still readable afterwards.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: data RAM for the MIPS core's data port, plus a store trace FIFO and pass/fail flags.
// Latency: reads are combinational; memory, flags and count update at the storing edge; trace head appears 1 cycle later.
// Backpressure: none toward the core; a full trace FIFO drops the store (sticky trace_overflow). Trace built only with `DMEM_TRACE_EN.

`ifdef DMEM_TRACE_EN
// Show-ahead FIFO; head reads 0 while empty so the trace outputs are clean after reset.
module dmem_trace_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop_req,
  input  logic [W-1:0] din,
  output logic         vld,
  output logic         full,
  output logic [W-1:0] dout
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] store_q [DEPTH];
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic         empty;
  logic         pop;
  logic         wr_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop   = pop_req && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign wr_en = push && (!full || pop);
  assign vld   = !empty;
  assign dout  = empty ? '0 : store_q[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) store_q[wr_ptr[PW-1:0]] <= din;
  end
endmodule
`endif

module data_mem_responder #(
  parameter int          AW          = 6,
  parameter int          TRACE_DEPTH = 8,
  parameter logic [31:0] PASS_ADDR   = 32'd84,
  parameter logic [31:0] PASS_DATA   = 32'd7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        misaligned,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic        trace_overflow,
  output logic [15:0] store_count,
  output logic        pass,
  output logic        fail
);
  logic [31:0]   mem [2**AW];
  logic [AW-1:0] idx;
  logic          accepted;
  logic          bad_store;

  assign idx       = dataadr[AW+1:2];
  assign accepted  = memwrite && (dataadr[1:0] == 2'b00);
  assign bad_store = memwrite && (dataadr[1:0] != 2'b00);
  assign readdata  = mem[idx];

  // Memory contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (accepted) mem[idx] <= writedata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misaligned  <= 1'b0;
      store_count <= 16'd0;
      pass        <= 1'b0;
      fail        <= 1'b0;
    end else begin
      if (bad_store) misaligned <= 1'b1;
      if (accepted && store_count != 16'hFFFF) store_count <= store_count + 16'd1;
      if (accepted && dataadr == PASS_ADDR) begin
        if (writedata == PASS_DATA) pass <= 1'b1;
        else                        fail <= 1'b1;
      end
    end
  end

`ifdef DMEM_TRACE_EN
  logic        fifo_full;
  logic [63:0] fifo_head;

  dmem_trace_fifo #(
    .W     (64),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (accepted),
    .pop_req (trace_ready),
    .din     ({dataadr, writedata}),
    .vld     (trace_valid),
    .full    (fifo_full),
    .dout    (fifo_head)
  );

  assign trace_addr = fifo_head[63:32];
  assign trace_data = fifo_head[31:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trace_overflow <= 1'b0;
    end else if (accepted && fifo_full && !(trace_valid && trace_ready)) begin
      trace_overflow <= 1'b1;
    end
  end
`else
  logic unused_trace_ready;

  assign unused_trace_ready = trace_ready;
  assign trace_valid        = 1'b0;
  assign trace_addr         = 32'd0;
  assign trace_data         = 32'd0;
  assign trace_overflow     = 1'b0;
`endif
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed and random bench for data_mem_responder against a queue/array reference model.
module tb_data_mem_responder;
  localparam int AW    = 6;
  localparam int DEPTH = 8;
`ifdef DMEM_TRACE_EN
  localparam bit TRACE_EN = 1'b1;
`else
  localparam bit TRACE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        misaligned;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic        trace_overflow;
  logic [15:0] store_count;
  logic        pass;
  logic        fail;

  data_mem_responder dut (
    .clk            (clk),
    .rst            (rst),
    .memwrite       (memwrite),
    .dataadr        (dataadr),
    .writedata      (writedata),
    .readdata       (readdata),
    .misaligned     (misaligned),
    .trace_valid    (trace_valid),
    .trace_ready    (trace_ready),
    .trace_addr     (trace_addr),
    .trace_data     (trace_data),
    .trace_overflow (trace_overflow),
    .store_count    (store_count),
    .pass           (pass),
    .fail           (fail)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_mem   [64];
  bit          m_known [64];
  logic [31:0] q_addr  [$];
  logic [31:0] q_data  [$];
  bit          m_mis, m_ovf, m_pass, m_fail;
  int          m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mis  = 1'b0;
    m_ovf  = 1'b0;
    m_pass = 1'b0;
    m_fail = 1'b0;
    m_cnt  = 0;
    q_addr.delete();
    q_data.delete();
  endtask

  // Apply the current inputs at the next rising edge in the model, then step the DUT.
  task automatic tick();
    int          idx;
    bit          pop, acc, was_full;
    logic [31:0] dummy;
    idx      = int'(dataadr[AW+1:2]);
    pop      = TRACE_EN && (q_addr.size() > 0) && trace_ready;
    was_full = (q_addr.size() == DEPTH);
    acc      = memwrite && (dataadr[1:0] == 2'b00);
    if (pop) begin
      dummy = q_addr.pop_front();
      dummy = q_data.pop_front();
    end
    if (memwrite && !acc) m_mis = 1'b1;
    if (acc) begin
      m_mem[idx]   = writedata;
      m_known[idx] = 1'b1;
      if (m_cnt < 65535) m_cnt++;
      if (dataadr == 32'd84) begin
        if (writedata == 32'd7) m_pass = 1'b1;
        else                    m_fail = 1'b1;
      end
      if (TRACE_EN) begin
        if (!was_full || pop) begin
          q_addr.push_back(dataadr);
          q_data.push_back(writedata);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    int idx;
    bit has;
    idx = int'(dataadr[AW+1:2]);
    has = (q_addr.size() > 0);
    if (m_known[idx]) chk({tag, ":readdata"}, readdata, m_mem[idx]);
    chk({tag, ":misaligned"},  {31'd0, misaligned},     {31'd0, m_mis});
    chk({tag, ":pass"},        {31'd0, pass},           {31'd0, m_pass});
    chk({tag, ":fail"},        {31'd0, fail},           {31'd0, m_fail});
    chk({tag, ":store_count"}, {16'd0, store_count},    32'(m_cnt));
    chk({tag, ":trace_valid"}, {31'd0, trace_valid},    {31'd0, has});
    chk({tag, ":overflow"},    {31'd0, trace_overflow}, {31'd0, m_ovf});
    chk({tag, ":trace_addr"},  trace_addr, has ? q_addr[0] : 32'd0);
    chk({tag, ":trace_data"},  trace_data, has ? q_data[0] : 32'd0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite  = 1'b1;
    dataadr   = a;
    writedata = d;
    tick();
  endtask

  task automatic idle(input logic [31:0] a);
    memwrite = 1'b0;
    dataadr  = a;
    tick();
  endtask

  task automatic do_reset_sync();
    rst = 1'b0;
    #2;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    for (int i = 0; i < 64; i++) m_known[i] = 1'b0;
    model_reset();
    rst         = 1'b0;
    memwrite    = 1'b0;
    dataadr     = 32'd0;
    writedata   = 32'd0;
    trace_ready = 1'b0;
    #12;
    check_all("por");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Completion store with the pass value, then read it back.
    store(32'd84, 32'h0000_0007); check_all("pass_store");
    idle(32'd84);                 check_all("pass_read");

    do_reset_sync();
    store(32'd84, 32'h0000_0005); check_all("fail_first");
    store(32'd84, 32'h0000_0007); check_all("pass_second");
    idle(32'd0);                  check_all("flags_hold");

    // Misaligned store leaves word 80 intact.
    store(32'd80, 32'h1111_1111);
    store(32'd82, 32'hDEAD_BEEF); check_all("misaligned_store");
    idle(32'd80);                 check_all("misaligned_read80");

    // Nine stores into a depth-8 FIFO with no reader.
    do_reset_sync();
    for (int i = 0; i < 9; i++) store(32'(4 * i), 32'hA000_0000 + 32'(i));
    idle(32'd32);                 check_all("overflow");
    trace_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_all("drain");
      idle(32'd0);
    end
    check_all("drained");

    // Full FIFO with a concurrent pop accepts the new store.
    trace_ready = 1'b0;
    do_reset_sync();
    for (int i = 0; i < 8; i++) store(32'd100 + 32'(4 * i), 32'hB000_0000 + 32'(i));
    check_all("full");
    trace_ready = 1'b1;
    store(32'd40, 32'h0000_1234); check_all("push_pop_full");
    for (int i = 0; i < 8; i++) begin
      check_all("drain2");
      idle(32'd40);
    end
    check_all("drained2");

    // Asynchronous reset between edges with three queued entries.
    trace_ready = 1'b0;
    store(32'd8,  32'hC000_0001);
    store(32'd12, 32'hC000_0002);
    store(32'd16, 32'hC000_0003);
    memwrite = 1'b0;
    dataadr  = 32'd12;
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("mid_reset");
    @(negedge clk);
    rst = 1'b1;
    idle(32'd12);                 check_all("after_reset_read");

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      r = int'($urandom_range(0, 9));
      if (r == 0)      a[1:0]  = 2'($urandom_range(1, 3));
      else if (r == 1) a[31:8] = 24'($urandom);
      else if (r == 2) a       = 32'd84;
      memwrite    = ($urandom_range(0, 2) != 0);
      dataadr     = a;
      writedata   = (r == 2 && $urandom_range(0, 1) == 1) ? 32'd7 : $urandom;
      trace_ready = ($urandom_range(0, 3) != 0);
      tick();
      check_all("random");
    end

    // Saturate store_count.
    trace_ready = 1'b1;
    for (int n = 0; n < 65540; n++) store(32'd4, 32'(n));
    check_all("saturate");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
